// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : alu_pkg
//  Description : Opcode encodings and controller state type shared by the
//                sequential ALU and its iterative multiply/divide core.
//  Revision    : 1.0 - initial release
// ============================================================================
package alu_pkg;

   // Single-cycle opcodes
   localparam logic [4:0] OP_ADD   = 5'h00;
   localparam logic [4:0] OP_SUB   = 5'h01;
   localparam logic [4:0] OP_OR    = 5'h02;
   localparam logic [4:0] OP_ORI   = 5'h03;
   localparam logic [4:0] OP_SRL   = 5'h04;
   localparam logic [4:0] OP_SLL   = 5'h05;
   localparam logic [4:0] OP_LUI   = 5'h06;
   localparam logic [4:0] OP_ANDI  = 5'h07;
   localparam logic [4:0] OP_NOR   = 5'h0C;
   localparam logic [4:0] OP_AND   = 5'h0D;

   // Extended opcodes
   localparam logic [4:0] OP_MULTU = 5'h10;
   localparam logic [4:0] OP_MULT  = 5'h11;
   localparam logic [4:0] OP_DIVU  = 5'h12;
   localparam logic [4:0] OP_DIV   = 5'h13;
   localparam logic [4:0] OP_MFHI  = 5'h14;
   localparam logic [4:0] OP_MFLO  = 5'h15;

   // Controller states for iterative operations
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_FIX  = 2'd2
   } state_t;

   // True for the opcodes that go through the multi-cycle core
   function automatic logic is_iterative(input logic [4:0] op);
      return (op == OP_MULTU) || (op == OP_MULT) ||
             (op == OP_DIVU)  || (op == OP_DIV);
   endfunction

endpackage
`default_nettype wire

// File: rtl/seq_muldiv_core.sv
`default_nettype none
// ============================================================================
//  Module      : seq_muldiv_core
//  Description : Radix-2 iterative multiplier (shift-add) and restoring
//                divider on operand magnitudes, with sign fix-up on the
//                result outputs. One step per cycle, WIDTH steps in total.
//  Revision    : 1.0 - initial release
// ============================================================================
module seq_muldiv_core #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             load_i,
   input  logic             div_i,
   input  logic             signed_i,
   input  logic [WIDTH-1:0] a_i,
   input  logic [WIDTH-1:0] b_i,
   input  logic             step_i,
   output logic             last_o,
   output logic [WIDTH-1:0] hi_o,
   output logic [WIDTH-1:0] lo_o,
   output logic             div_by_zero_o
);

   localparam int CNT_W = $clog2(WIDTH);

   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [WIDTH-1:0]   hi_q, hi_d;        // product high half / partial remainder
   logic [WIDTH-1:0]   lo_q, lo_d;        // multiplier bits / dividend -> quotient
   logic [WIDTH-1:0]   mag_b_q, mag_b_d;  // multiplicand or divisor magnitude
   logic               div_q, div_d;
   logic               neg_lo_q, neg_lo_d;
   logic               neg_hi_q, neg_hi_d;

   logic [WIDTH-1:0]   mag_a, mag_b;
   logic [WIDTH:0]     add_sum;
   logic [WIDTH:0]     shifted;
   logic [WIDTH:0]     diff;
   logic [2*WIDTH-1:0] prod;

   // Operand load and one multiply or divide step per cycle
   always_comb begin
      mag_a   = (signed_i && a_i[WIDTH-1]) ? -a_i : a_i;
      mag_b   = (signed_i && b_i[WIDTH-1]) ? -b_i : b_i;
      add_sum = {1'b0, hi_q} + (lo_q[0] ? {1'b0, mag_b_q} : {(WIDTH+1){1'b0}});
      shifted = {hi_q, lo_q[WIDTH-1]};
      diff    = shifted - {1'b0, mag_b_q};

      cnt_d    = cnt_q;
      hi_d     = hi_q;
      lo_d     = lo_q;
      mag_b_d  = mag_b_q;
      div_d    = div_q;
      neg_lo_d = neg_lo_q;
      neg_hi_d = neg_hi_q;

      if (load_i) begin
         cnt_d    = '0;
         hi_d     = '0;
         lo_d     = mag_a;
         mag_b_d  = mag_b;
         div_d    = div_i;
         // A zero divisor keeps the all-ones quotient un-negated, while the
         // remainder (the dividend magnitude) still gets the dividend's sign.
         neg_lo_d = signed_i && (a_i[WIDTH-1] ^ b_i[WIDTH-1]) &&
                    !(div_i && (b_i == '0));
         neg_hi_d = signed_i && a_i[WIDTH-1];
      end else if (step_i) begin
         cnt_d = cnt_q + 1'b1;
         if (div_q) begin
            // Restoring step: keep the subtraction only when it does not borrow
            if (!diff[WIDTH]) begin
               hi_d = diff[WIDTH-1:0];
               lo_d = {lo_q[WIDTH-2:0], 1'b1};
            end else begin
               hi_d = shifted[WIDTH-1:0];
               lo_d = {lo_q[WIDTH-2:0], 1'b0};
            end
         end else begin
            hi_d = add_sum[WIDTH:1];
            lo_d = {add_sum[0], lo_q[WIDTH-1:1]};
         end
      end
   end

   // Sign fix-up of the finished magnitudes and step-count terminal flag
   always_comb begin
      prod = {hi_q, lo_q};
      if (div_q) begin
         lo_o = neg_lo_q ? -lo_q : lo_q;
         hi_o = neg_hi_q ? -hi_q : hi_q;
      end else begin
         {hi_o, lo_o} = neg_lo_q ? -prod : prod;
      end
      div_by_zero_o = div_q && (mag_b_q == '0);
      last_o        = (cnt_q == CNT_W'(WIDTH-1));
   end

   // Datapath and step-counter registers
   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_q    <= '0;
         hi_q     <= '0;
         lo_q     <= '0;
         mag_b_q  <= '0;
         div_q    <= 1'b0;
         neg_lo_q <= 1'b0;
         neg_hi_q <= 1'b0;
      end else begin
         cnt_q    <= cnt_d;
         hi_q     <= hi_d;
         lo_q     <= lo_d;
         mag_b_q  <= mag_b_d;
         div_q    <= div_d;
         neg_lo_q <= neg_lo_d;
         neg_hi_q <= neg_hi_d;
      end
   end

endmodule
`default_nettype wire

// File: rtl/seq_alu.sv
`default_nettype none
// ============================================================================
//  Module      : seq_alu
//  Description : Sequential ALU. Logic/arithmetic/shift ops complete in one
//                cycle; multiply and divide run on an iterative core and
//                deposit their result in the HI/LO registers.
//  Revision    : 1.0 - initial release
// ============================================================================
module seq_alu
   import alu_pkg::*;
#(
   parameter int WIDTH   = 32,
   parameter int SHAMT_W = $clog2(WIDTH)
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               start_i,
   input  logic [4:0]         alu_operation_i,
   input  logic [WIDTH-1:0]   a_i,
   input  logic [WIDTH-1:0]   b_i,
   input  logic [SHAMT_W-1:0] shamt_i,
   input  logic [WIDTH/2-1:0] imm_i,
   output logic               busy_o,
   output logic               done_o,
   output logic [WIDTH-1:0]   alu_data_o,
   output logic               zero_o,
   output logic [WIDTH-1:0]   hi_o,
   output logic [WIDTH-1:0]   lo_o,
   output logic               div_by_zero_o
);

   localparam int HALF = WIDTH / 2;

   state_t             state_q, state_d;
   logic               core_load, core_step, core_last, core_dbz;
   logic               single_acc, fix;
   logic [WIDTH-1:0]   core_hi, core_lo, single_res;

   logic [WIDTH-1:0]   alu_data_q, alu_data_d;
   logic [WIDTH-1:0]   hi_q, hi_d;
   logic [WIDTH-1:0]   lo_q, lo_d;
   logic               zero_q, zero_d;
   logic               done_q, done_d;
   logic               dbz_q, dbz_d;

   seq_muldiv_core #(
      .WIDTH (WIDTH)
   ) u_core (
      .clk           (clk),
      .reset         (reset),
      .load_i        (core_load),
      .div_i         ((alu_operation_i == OP_DIVU) || (alu_operation_i == OP_DIV)),
      .signed_i      ((alu_operation_i == OP_MULT) || (alu_operation_i == OP_DIV)),
      .a_i           (a_i),
      .b_i           (b_i),
      .step_i        (core_step),
      .last_o        (core_last),
      .hi_o          (core_hi),
      .lo_o          (core_lo),
      .div_by_zero_o (core_dbz)
   );

   // Combinational result of every single-cycle opcode
   always_comb begin
      single_res = '0;
      case (alu_operation_i)
         OP_ADD:  single_res = a_i + b_i;
         OP_SUB:  single_res = a_i - b_i;
         OP_OR:   single_res = a_i | b_i;
         OP_ORI:  single_res = a_i | {{HALF{1'b0}}, imm_i};
         OP_SRL:  single_res = b_i >> shamt_i;
         OP_SLL:  single_res = b_i << shamt_i;
         OP_LUI:  single_res = {imm_i, {HALF{1'b0}}};
         OP_ANDI: single_res = a_i & {{HALF{1'b0}}, imm_i};
         OP_NOR:  single_res = ~(a_i | b_i);
         OP_AND:  single_res = a_i & b_i;
         OP_MFHI: single_res = hi_q;
         OP_MFLO: single_res = lo_q;
         default: single_res = '0;
      endcase
   end

   // Controller next state: accept in IDLE, WIDTH core steps in RUN, commit in FIX
   always_comb begin
      state_d    = state_q;
      core_load  = 1'b0;
      core_step  = 1'b0;
      fix        = 1'b0;
      single_acc = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (start_i) begin
               if (is_iterative(alu_operation_i)) begin
                  core_load = 1'b1;
                  state_d   = ST_RUN;
               end else begin
                  single_acc = 1'b1;
               end
            end
         end
         ST_RUN: begin
            core_step = 1'b1;
            if (core_last) begin
               state_d = ST_FIX;
            end
         end
         ST_FIX: begin
            fix     = 1'b1;
            state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Next value of the architectural result registers
   always_comb begin
      alu_data_d = alu_data_q;
      zero_d     = zero_q;
      hi_d       = hi_q;
      lo_d       = lo_q;
      dbz_d      = dbz_q;
      done_d     = single_acc | fix;
      if (single_acc) begin
         alu_data_d = single_res;
         zero_d     = (single_res == '0);
         dbz_d      = 1'b0;
      end
      if (fix) begin
         hi_d       = core_hi;
         lo_d       = core_lo;
         alu_data_d = core_lo;
         zero_d     = (core_lo == '0);
         dbz_d      = core_dbz;
      end
   end

   // State and result registers; reset aborts any operation in flight
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= ST_IDLE;
         alu_data_q <= '0;
         zero_q     <= 1'b1;
         hi_q       <= '0;
         lo_q       <= '0;
         done_q     <= 1'b0;
         dbz_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         alu_data_q <= alu_data_d;
         zero_q     <= zero_d;
         hi_q       <= hi_d;
         lo_q       <= lo_d;
         done_q     <= done_d;
         dbz_q      <= dbz_d;
      end
   end

   assign busy_o        = (state_q != ST_IDLE);
   assign done_o        = done_q;
   assign alu_data_o    = alu_data_q;
   assign zero_o        = zero_q;
   assign hi_o          = hi_q;
   assign lo_o          = lo_q;
   assign div_by_zero_o = dbz_q;

endmodule
`default_nettype wire

// File: doc/seq_alu.md
SEQ_ALU -- requirements
Module: seq_alu

Interface
REQ-001 Parameter WIDTH, default 32, datapath width in bits; legal values are even and at least 8.
REQ-002 Parameter SHAMT_W, default $clog2(WIDTH), shift-amount width.
REQ-003 Port clk, input, 1 bit: the single clock; every register updates on the rising edge.
REQ-004 Port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 Port start_i, input, 1 bit: operation request, accepted only when busy_o=0.
REQ-006 Port alu_operation_i, input, 5 bits: opcode, sampled on acceptance.
REQ-007 Ports a_i and b_i, input, WIDTH bits each: operands, sampled on acceptance.
REQ-008 Port shamt_i, input, SHAMT_W bits: shift amount.
REQ-009 Port imm_i, input, WIDTH/2 bits: immediate.
REQ-010 Port busy_o, output, 1 bit: an iterative operation is in progress.
REQ-011 Port done_o, output, 1 bit: one-cycle result-valid pulse.
REQ-012 Port alu_data_o, output, WIDTH bits: registered result.
REQ-013 Port zero_o, output, 1 bit: high when alu_data_o==0; registered together with alu_data_o.
REQ-014 Ports hi_o and lo_o, output, WIDTH bits each: HI and LO architectural registers.
REQ-015 Port div_by_zero_o, output, 1 bit: valid with done_o on DIV/DIVU only.

Function
REQ-016 Opcodes 0x00-0x0F:
- ADD=0, SUB=1, OR=2, ORI=3, SRL=4, SLL=5, LUI=6, ANDI=7, NOR=0xC, AND=0xD.
- ORI/ANDI zero-extend imm_i; LUI = {imm_i, WIDTH/2 zeros}; SLL/SRL shift b_i by shamt_i, logical.
- All other codes 0x00-0x0F return 0.
REQ-017 Extended opcodes:
- MULTU=0x10, MULT=0x11, DIVU=0x12, DIV=0x13, MFHI=0x14, MFLO=0x15.
- Codes 0x16-0x1F return 0 with single-cycle timing.
REQ-018 Acceptance:
- A request is accepted at an edge where start_i=1 and busy_o=0.
- start_i while busy_o=1 is ignored, with no queuing.
REQ-019 Single-cycle ops (all except MULT/MULTU/DIV/DIVU): alu_data_o and zero_o update at the acceptance edge, and done_o=1 for the following cycle.
REQ-020 Back-to-back single-cycle requests are accepted every cycle, with done_o held high continuously.
REQ-021 Iterative ops, timing:
- FSM states: IDLE, RUN, FIX.
- Acceptance moves IDLE->RUN and loads operand magnitudes.
- RUN lasts exactly WIDTH cycles (one shift-add or restore-subtract step each), then moves to FIX.
- FIX applies the signs, writes HI/LO, then returns to IDLE.
- done_o is high in the cycle after FIX: WIDTH+2 cycles after acceptance.
- busy_o is high in RUN and FIX only.
REQ-022 MULT/MULTU: {HI,LO} = the 2*WIDTH-bit product, signed or unsigned respectively.
REQ-023 DIV/DIVU: LO = quotient, HI = remainder.
- Signed division truncates toward zero.
- The remainder takes the dividend's sign.
REQ-024 Division by zero: LO=all ones, HI=a_i, div_by_zero_o=1, with full latency preserved.
REQ-025 DIV of most-negative value by -1: LO = most-negative value, HI=0, div_by_zero_o=0.
REQ-026 For iterative ops, alu_data_o = new LO and zero_o reflects LO; HI/LO change only in FIX.
REQ-027 MFHI/MFLO return the current HI/LO as single-cycle ops.
REQ-028 A start_i during the done_o cycle is accepted, since busy_o=0 in that cycle.

Reset
REQ-029 Reset drives the following at the next edge:
- FSM to IDLE.
- busy_o, done_o and div_by_zero_o to 0.
- alu_data_o, hi_o and lo_o to 0.
- zero_o to 1.
REQ-030 Reset during RUN/FIX aborts the operation; no partial result reaches HI/LO and done_o does not pulse.
REQ-031 Reset has priority over start_i in the same cycle.

Structure
REQ-032 Package alu_pkg holds the opcode localparams and the FSM state typedef.
REQ-033 Sub-module seq_muldiv_core is parametrised by WIDTH.
- It contains the iterative multiplier/divider and its step counter.
- seq_alu contains the combinational op decode, the FSM control and the HI/LO registers.

Verification
REQ-034 ADD: a=0x7FFFFFFF, b=1 -> alu_data_o=0x80000000, zero_o=0, done_o one cycle later.
REQ-035 MULT: a=0xFFFFFFFE (-2), b=3 -> HI=0xFFFFFFFF, LO=0xFFFFFFFA, done_o exactly 34 cycles after acceptance; start_i pulsed mid-run is ignored.
REQ-036 DIV: a=-7, b=2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF; then MFHI -> 0xFFFFFFFF.
REQ-037 DIVU: a=5, b=0 -> div_by_zero_o=1, LO=0xFFFFFFFF, HI=5; DIV 0x80000000 by -1 -> LO=0x80000000, HI=0.
REQ-038 Reset asserted at RUN cycle 10 of a MULTU -> IDLE next cycle, hi_o=lo_o=0, no done_o; a new SUB 5-5 is then accepted -> zero_o=1.
REQ-039 Run the same MULT and DIV checks at WIDTH=8 (latency 10) and compare against a reference model over 1000 random operand pairs.
